// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access encodings, FSM states,
// exception causes and load/store classification helpers.
package load_store_unit_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LH   = 4'd2,
    LW   = 4'd3,
    LBU  = 4'd4,
    LHU  = 4'd5,
    SB   = 4'd6,
    SH   = 4'd7,
    SW   = 4'd8
  } mem_access_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2,
    EXC  = 2'd3
  } lsu_state_t;

  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;

  function automatic logic is_load(input mem_access_type t);
    return (t == LB) || (t == LH) || (t == LW) || (t == LBU) || (t == LHU);
  endfunction

  function automatic logic is_store(input mem_access_type t);
    return (t == SB) || (t == SH) || (t == SW);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane logic for the load/store unit: store lane placement, load
// extraction with sign/zero extension, and the misalignment check on the
// operation being offered at the input.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  mem_access_type i_type,
  input  logic [1:0]     i_lane,
  input  logic [31:0]    i_store_data,
  input  logic [31:0]    i_rdata,
  input  mem_access_type i_chk_type,
  input  logic [1:0]     i_chk_lane,
  output logic [31:0]    o_wdata,
  output logic [3:0]     o_wstrb,
  output logic [31:0]    o_load_data,
  output logic           o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // store data replication and byte enables; loads drive nothing onto the bus
  always_comb begin
    o_wdata = 32'h0;
    o_wstrb = 4'b0000;
    case (i_type)
      SB: begin
        o_wdata = {4{i_store_data[7:0]}};
        o_wstrb = 4'b0001 << i_lane;
      end
      SH: begin
        o_wdata = {2{i_store_data[15:0]}};
        o_wstrb = i_lane[1] ? 4'b1100 : 4'b0011;
      end
      SW: begin
        o_wdata = i_store_data;
        o_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  // pick the addressed byte/half out of the read word and extend it
  always_comb begin
    w_byte = 8'h0;
    case (i_lane)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_load_data = 32'h0;
    case (i_type)
      LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
      LBU: o_load_data = {24'h0, w_byte};
      LH:  o_load_data = {{16{w_half[15]}}, w_half};
      LHU: o_load_data = {16'h0, w_half};
      LW:  o_load_data = i_rdata;
      default: ;
    endcase
  end

  // halves need an even address, words a 4-byte aligned one
  always_comb begin
    o_misaligned = 1'b0;
    case (i_chk_type)
      LH, LHU, SH: o_misaligned = i_chk_lane[0];
      LW, SW:      o_misaligned = (i_chk_lane != 2'b00);
      default:     o_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one decoded load/store, runs a single req/ack data
// bus transaction with timeout, and reports either a writeback or an
// exception pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  mem_access_type access_type,
  input  logic [31:0]    addr,
  input  logic [31:0]    store_data,
  input  logic [4:0]     rd,
  output logic           mem_req,
  output logic           mem_we,
  output logic [31:0]    mem_addr,
  output logic [3:0]     mem_wstrb,
  output logic [31:0]    mem_wdata,
  input  logic           mem_ack,
  input  logic           mem_err,
  input  logic [31:0]    mem_rdata,
  output logic           wb_valid,
  output logic           wb_we,
  output logic [4:0]     wb_rd,
  output logic [31:0]    wb_data,
  output logic           exc_valid,
  output logic [3:0]     exc_cause,
  output logic [31:0]    exc_tval
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t     r_state;
  lsu_state_t     w_next_state;
  mem_access_type r_type;
  logic [31:0]    r_addr;
  logic [31:0]    r_store_data;
  logic [4:0]     r_rd;
  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_cause;
  logic [31:0]    r_wb_data;

  logic           w_accept;
  logic           w_misaligned;
  logic           w_timeout;
  logic           w_in_bus;
  logic [31:0]    w_wdata;
  logic [3:0]     w_wstrb;
  logic [31:0]    w_load_data;

  assign w_accept  = in_valid && in_ready;
  assign w_in_bus  = (r_state == BUS);
  // last unacknowledged cycle: the counter holds how many have gone before
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  load_store_unit_align u_align (
    .i_type       (r_type),
    .i_lane       (r_addr[1:0]),
    .i_store_data (r_store_data),
    .i_rdata      (mem_rdata),
    .i_chk_type   (access_type),
    .i_chk_lane   (addr[1:0]),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misaligned)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // next-state decode; an ack beats a timeout landing on the same cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && (access_type != NONE))
          w_next_state = w_misaligned ? EXC : BUS;
      end
      BUS: begin
        if (mem_ack)        w_next_state = mem_err ? EXC : RESP;
        else if (w_timeout) w_next_state = EXC;
      end
      RESP:    w_next_state = IDLE;
      EXC:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // operation latches, timeout counter, exception cause and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type       <= NONE;
      r_addr       <= 32'h0;
      r_store_data <= 32'h0;
      r_rd         <= 5'd0;
      r_cnt        <= '0;
      r_cause      <= 4'd0;
      r_wb_data    <= 32'h0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_type       <= access_type;
        r_addr       <= addr;
        r_store_data <= store_data;
        r_rd         <= rd;
        r_cnt        <= '0;
        r_wb_data    <= 32'h0;
        r_cause      <= is_load(access_type) ? EXC_LOAD_MISALIGNED
                                             : EXC_STORE_MISALIGNED;
      end
    end else if (w_in_bus) begin
      if (mem_ack) begin
        if (mem_err)
          r_cause <= is_load(r_type) ? EXC_LOAD_FAULT : EXC_STORE_FAULT;
        else if (is_load(r_type))
          r_wb_data <= w_load_data;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (w_timeout)
          r_cause <= is_load(r_type) ? EXC_LOAD_FAULT : EXC_STORE_FAULT;
      end
    end
  end

  // outputs decoded from registered state so they drop straight away on reset
  always_comb begin
    in_ready  = (r_state == IDLE);
    mem_req   = w_in_bus;
    mem_we    = w_in_bus && is_store(r_type);
    mem_addr  = w_in_bus ? {r_addr[31:2], 2'b00} : 32'h0;
    mem_wstrb = w_in_bus ? w_wstrb : 4'b0000;
    mem_wdata = w_in_bus ? w_wdata : 32'h0;
    wb_valid  = (r_state == RESP);
    wb_we     = wb_valid && is_load(r_type) && (r_rd != 5'd0);
    wb_rd     = wb_valid ? r_rd : 5'd0;
    wb_data   = wb_valid ? r_wb_data : 32'h0;
    exc_valid = (r_state == EXC);
    exc_cause = exc_valid ? r_cause : 4'd0;
    exc_tval  = exc_valid ? r_addr : 32'h0;
  end

endmodule
